nes_pad_reader: RTL and testbench

Serial front end for the NES controller. It generates the `latch` and `nes_clk` waveforms and shifts in the controller's 8-bit serial `data` stream once per poll period. It publishes a registered, active-high button vector together with one-cycle press-edge flags. It sits directly upstream of the debounce/game FSM, and its `buttons` ordering matches the game's `nesin` vector `{right,left,down,up,start,select,b,a}`.

---
 rtl/nes_pad_reader_pkg.sv | 31 +++
 rtl/nes_pad_reader_if.sv | 13 +
 rtl/nes_pad_reader_poll_timer.sv | 29 ++
 rtl/nes_pad_reader.sv | 133 +++++++++++++
 tb/tb_nes_pad_reader.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/nes_pad_reader_pkg.sv
// Shared constants and types for the NES controller front end.
// Button bit positions match the game's nesin vector {right,left,down,up,start,select,b,a}.
package nes_pkg;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   // 50 MHz system clock: 12 us latch, 6 us half period, 60 Hz poll
   localparam int DEF_LATCH_CYC = 600;
   localparam int DEF_HALF_CYC  = 300;
   localparam int DEF_POLL_CYC  = 833333;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LATCH  = 3'd1,
      CLK_HI = 3'd2,
      CLK_LO = 3'd3,
      DONE   = 3'd4
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nes_pad_reader_if.sv
// Controller-side wires plus the published button vector of the pad reader.
// master = the reader itself, slave = the controller/consumer side.
interface nes_pad_if;
   logic       data;
   logic       latch;
   logic       nes_clk;
   logic [7:0] buttons;
   logic       valid;
   logic [7:0] press;

   modport master (input data, output latch, nes_clk, buttons, valid, press);
   modport slave  (output data, input latch, nes_clk, buttons, valid, press);
endinterface

// File: rtl/nes_pad_reader_poll_timer.sv
// Free-running 0..POLL_CYC-1 divider; frame_start_o is high while the count is 0.
module nes_poll_timer
   import nes_pkg::*;
#(
   parameter int POLL_CYC = DEF_POLL_CYC
) (
   input  logic clk,
   input  logic rst,
   output logic frame_start_o
);

   localparam int CNT_W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == CNT_W'(POLL_CYC - 1)) ? '0 : cnt_q + CNT_W'(1);
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // Count is 0 on the first edge after reset, so the first frame starts at once
   assign frame_start_o = (cnt_q == '0);

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller serial reader: drives latch/nes_clk, shifts in 8 active-low bits
// and publishes an active-high button vector with one-cycle valid/press flags.
module nes_pad_reader
   import nes_pkg::*;
#(
   parameter int LATCH_CYC = DEF_LATCH_CYC,
   parameter int HALF_CYC  = DEF_HALF_CYC,
   parameter int POLL_CYC  = DEF_POLL_CYC
) (
   input  logic      clk,
   input  logic      rst,
   nes_pad_if.master pad
);

   localparam int PH_MAX = max_int(LATCH_CYC, HALF_CYC);
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   logic            frame_start;
   state_e          state_q, state_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            latch_q, latch_d;
   logic            nes_clk_q, nes_clk_d;
   logic [7:0]      buttons_q, buttons_d;
   logic            valid_q, valid_d;
   logic [7:0]      press_q, press_d;
   logic            phase_last;

   nes_poll_timer #(.POLL_CYC(POLL_CYC)) u_poll_timer (
      .clk           (clk),
      .rst           (rst),
      .frame_start_o (frame_start)
   );

   assign phase_last = (state_q == LATCH) ? (phase_q == PH_W'(LATCH_CYC - 1))
                                          : (phase_q == PH_W'(HALF_CYC - 1));

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path infers a latch.
      state_d   = state_q;
      phase_d   = '0;
      idx_d     = idx_q;
      shift_d   = shift_q;
      latch_d   = latch_q;
      nes_clk_d = nes_clk_q;
      buttons_d = buttons_q;
      valid_d   = 1'b0;
      press_d   = 8'h00;

      case (state_q)
         IDLE: begin
            if (frame_start) begin
               state_d = LATCH;
               latch_d = 1'b1;
            end
         end
         LATCH: begin
            if (phase_last) begin
               shift_d[0] = ~pad.data;
               idx_d      = 3'd1;
               latch_d    = 1'b0;
               nes_clk_d  = 1'b1;
               state_d    = CLK_HI;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         CLK_HI: begin
            if (phase_last) begin
               nes_clk_d = 1'b0;
               state_d   = CLK_LO;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         CLK_LO: begin
            if (phase_last) begin
               shift_d[idx_q] = ~pad.data;
               if (idx_q == 3'd7) begin
                  // Publish on entry so valid is high for the single DONE cycle
                  buttons_d = shift_d;
                  press_d   = shift_d & ~buttons_q;
                  valid_d   = 1'b1;
                  state_d   = DONE;
               end else begin
                  idx_d     = idx_q + 3'd1;
                  nes_clk_d = 1'b1;
                  state_d   = CLK_HI;
               end
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         DONE: begin
            idx_d   = 3'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         idx_q     <= 3'd0;
         shift_q   <= 8'h00;
         latch_q   <= 1'b0;
         nes_clk_q <= 1'b0;
         buttons_q <= 8'h00;
         valid_q   <= 1'b0;
         press_q   <= 8'h00;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         latch_q   <= latch_d;
         nes_clk_q <= nes_clk_d;
         buttons_q <= buttons_d;
         valid_q   <= valid_d;
         press_q   <= press_d;
      end
   end

   assign pad.latch   = latch_q;
   assign pad.nes_clk = nes_clk_q;
   assign pad.buttons = buttons_q;
   assign pad.valid   = valid_q;
   assign pad.press   = press_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader: a small-timing instance driven by a 4021-style
// controller model, plus a default-timing instance for waveform measurements.
module tb_nes_pad_reader;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   nes_pad_if pad ();
   nes_pad_if pad_d ();

   nes_pad_reader #(.LATCH_CYC(4), .HALF_CYC(2), .POLL_CYC(64)) u_dut (
      .clk (clk),
      .rst (rst),
      .pad (pad)
   );

   nes_pad_reader u_def (
      .clk (clk),
      .rst (rst),
      .pad (pad_d)
   );

   // Controller model: parallel load on latch, shift on each nes_clk rise
   logic [7:0] pressed = 8'h00;
   logic [7:0] snap    = 8'h00;
   logic [2:0] bit_idx = 3'd0;

   always @(posedge pad.latch) begin
      snap    = pressed;
      bit_idx = 3'd0;
   end

   always @(posedge pad.nes_clk) begin
      if (bit_idx != 3'd7) bit_idx = bit_idx + 3'd1;
   end

   assign pad.data   = ~snap[bit_idx];
   assign pad_d.data = 1'b1;

   typedef struct {
      logic [7:0] pat;
      logic [7:0] exp_btn;
      logic [7:0] exp_press;
   } frame_vec_t;

   frame_vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_valid(output int at_cyc);
      at_cyc = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (pad.valid) begin
            at_cyc = cyc;
            break;
         end
      end
      check("valid_seen", {31'd0, pad.valid}, 32'd1);
   endtask

   initial begin
      int at;
      int prev;
      int lat_hi, nclk_hi, rises, first_rise, second_rise, valid_c;
      logic prev_nclk;
      logic exp_latch, exp_nclk, exp_valid;

      tbl[0] = '{8'h00, 8'h00, 8'h00};
      tbl[1] = '{8'h09, 8'h09, 8'h09};
      tbl[2] = '{8'h88, 8'h88, 8'h80};
      tbl[3] = '{8'hFF, 8'hFF, 8'h77};
      tbl[4] = '{8'hFF, 8'hFF, 8'h00};

      // Reset state
      pressed = tbl[0].pat;
      repeat (3) @(negedge clk);
      check("rst_latch",   {31'd0, pad.latch},   32'd0);
      check("rst_nes_clk", {31'd0, pad.nes_clk}, 32'd0);
      check("rst_buttons", {24'd0, pad.buttons}, 32'd0);
      check("rst_valid",   {31'd0, pad.valid},   32'd0);
      check("rst_press",   {24'd0, pad.press},   32'd0);
      rst = 1'b0;

      // First frame, cycle by cycle waveform
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         exp_latch = (c >= 1 && c <= 4);
         exp_nclk  = (c >= 5 && c <= 32 && ((c - 5) % 4) < 2);
         exp_valid = (c == 33);
         check($sformatf("f0_latch_c%0d", c),   {31'd0, pad.latch},   {31'd0, exp_latch});
         check($sformatf("f0_nes_clk_c%0d", c), {31'd0, pad.nes_clk}, {31'd0, exp_nclk});
         check($sformatf("f0_valid_c%0d", c),   {31'd0, pad.valid},   {31'd0, exp_valid});
         check($sformatf("f0_press_c%0d", c),   {24'd0, pad.press},   32'd0);
         if (c == 33) begin
            check("f0_buttons", {24'd0, pad.buttons}, {24'd0, tbl[0].exp_btn});
            pressed = tbl[1].pat;
         end
      end

      // Table-driven frames: button patterns, press edges and 64-cycle spacing
      prev = 33;
      for (int i = 1; i < 5; i++) begin
         wait_valid(at);
         check($sformatf("f%0d_valid_cyc", i), at, prev + 64);
         check($sformatf("f%0d_buttons", i), {24'd0, pad.buttons}, {24'd0, tbl[i].exp_btn});
         check($sformatf("f%0d_press", i),   {24'd0, pad.press},   {24'd0, tbl[i].exp_press});
         prev = at;
         pressed = (i < 4) ? tbl[i + 1].pat : 8'h55;
         @(negedge clk);
         check($sformatf("f%0d_valid_1cyc", i), {31'd0, pad.valid}, 32'd0);
         check($sformatf("f%0d_press_1cyc", i), {24'd0, pad.press}, 32'd0);
         check($sformatf("f%0d_buttons_hold", i), {24'd0, pad.buttons}, {24'd0, tbl[i].exp_btn});
      end

      // Reset during the fourth nes_clk pulse of the next frame (cycles 337..338)
      for (int n = 0; n < 100 && cyc != 337; n++) @(negedge clk);
      check("mid_at_pulse4", cyc, 337);
      check("mid_nes_clk_hi", {31'd0, pad.nes_clk}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_latch",   {31'd0, pad.latch},   32'd0);
      check("mid_rst_nes_clk", {31'd0, pad.nes_clk}, 32'd0);
      check("mid_rst_buttons", {24'd0, pad.buttons}, 32'd0);
      check("mid_rst_valid",   {31'd0, pad.valid},   32'd0);
      check("mid_rst_press",   {24'd0, pad.press},   32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_valid(at);
      check("post_rst_valid_cyc", at, 33);
      check("post_rst_buttons", {24'd0, pad.buttons}, 32'h55);
      check("post_rst_press",   {24'd0, pad.press},   32'h55);

      // Default timing instance, measured from a fresh reset
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      lat_hi = 0; nclk_hi = 0; rises = 0; first_rise = -1; second_rise = -1; valid_c = -1;
      prev_nclk = 1'b0;
      for (int c = 1; c <= 6000; c++) begin
         @(negedge clk);
         if (pad_d.latch) lat_hi++;
         if (pad_d.nes_clk) nclk_hi++;
         if (pad_d.nes_clk && !prev_nclk) begin
            rises++;
            if (first_rise < 0) first_rise = c;
            else if (second_rise < 0) second_rise = c;
         end
         prev_nclk = pad_d.nes_clk;
         if (pad_d.valid) begin
            valid_c = c;
            break;
         end
      end
      check("def_latch_width",  lat_hi, 600);
      check("def_first_pulse",  first_rise, 601);
      check("def_nes_clk_per",  second_rise - first_rise, 600);
      check("def_nes_clk_high", nclk_hi, 7 * 300);
      check("def_pulse_count",  rises, 7);
      check("def_valid_cyc",    valid_c, 4801);
      check("def_buttons",      {24'd0, pad_d.buttons}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
